lock_sequencer: RTL and testbench

- Initiator side of the seconds-counter interface: drives the duration and counter reset, and consumes the counter's one-cycle expiry pulse.
- Runs one canal-lock cycle in three timed phases: ENTER (entry gate open), ADJUST (fill or drain), EXIT (exit gate open).
- Sits between the top-level user controls and the 1 Hz seconds counter. All timing in this block comes from the counter's expiry pulse.

---
 rtl/lock_sequencer.sv | 146 ++++++++++++++
 tb/tb_lock_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - canal lock cycle sequencer driving a seconds counter
//
// Runs one lock cycle as ENTER -> ADJUST -> EXIT, each phase timed by the
// external seconds counter: a LOAD cycle presents the duration with the
// counter held in reset, then a WAIT state runs until the counter's expiry
// pulse is sampled.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high
//   start           request a cycle (IDLE only); dir latched with it
//   dir             0 = raise (fill), 1 = lower (drain)
//   abort           cancel the running cycle, back to IDLE with no done
//   expire          counter expiry pulse
//   counter_seconds duration presented to the counter
//   counter_reset   counter reset, high in IDLE, LOAD_x and DONE
//   gate_in_open    entry gate command (ENTER)
//   gate_out_open   exit gate command (EXIT)
//   fill_valve      fill valve command (ADJUST, raising)
//   drain_valve     drain valve command (ADJUST, lowering)
//   busy            high from LOAD_ENTER through DONE
//   done            one-cycle completion pulse
//   phase           0 idle/done, 1 ENTER, 2 ADJUST, 3 EXIT

module lock_sequencer #(
  parameter int unsigned ENTER_SECS = 300,
  parameter int unsigned FILL_SECS  = 420,
  parameter int unsigned DRAIN_SECS = 480,
  parameter int unsigned EXIT_SECS  = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dir,
  input  logic       abort,
  input  logic       expire,
  output logic [9:0] counter_seconds,
  output logic       counter_reset,
  output logic       gate_in_open,
  output logic       gate_out_open,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       busy,
  output logic       done,
  output logic [1:0] phase
);

  localparam logic [9:0] C_ENTER = 10'(ENTER_SECS);
  localparam logic [9:0] C_FILL  = 10'(FILL_SECS);
  localparam logic [9:0] C_DRAIN = 10'(DRAIN_SECS);
  localparam logic [9:0] C_EXIT  = 10'(EXIT_SECS);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_ENTER = 3'd1,
    S_WAIT_ENTER = 3'd2,
    S_LOAD_ADJ   = 3'd3,
    S_WAIT_ADJ   = 3'd4,
    S_LOAD_EXIT  = 3'd5,
    S_WAIT_EXIT  = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_dir;
  logic   w_accept;

  // start with abort in IDLE is not accepted: abort wins.
  assign w_accept = (r_state == S_IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dir <= dir;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    if (abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:       if (w_accept) w_next = S_LOAD_ENTER;
        S_LOAD_ENTER: w_next = S_WAIT_ENTER;
        S_WAIT_ENTER: if (expire) w_next = S_LOAD_ADJ;
        S_LOAD_ADJ:   w_next = S_WAIT_ADJ;
        S_WAIT_ADJ:   if (expire) w_next = S_LOAD_EXIT;
        S_LOAD_EXIT:  w_next = S_WAIT_EXIT;
        S_WAIT_EXIT:  if (expire) w_next = S_DONE;
        S_DONE:       w_next = S_IDLE;
        default:      w_next = S_IDLE;
      endcase
    end
  end

  // Outputs decode only registered state (r_state, r_dir).
  always_comb begin
    counter_seconds = 10'd0;
    counter_reset   = 1'b1;
    gate_in_open    = 1'b0;
    gate_out_open   = 1'b0;
    fill_valve      = 1'b0;
    drain_valve     = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    phase           = 2'd0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD_ENTER, S_WAIT_ENTER: begin
        counter_seconds = C_ENTER;
        counter_reset   = (r_state == S_LOAD_ENTER);
        gate_in_open    = 1'b1;
        phase           = 2'd1;
      end
      S_LOAD_ADJ, S_WAIT_ADJ: begin
        counter_seconds = r_dir ? C_DRAIN : C_FILL;
        counter_reset   = (r_state == S_LOAD_ADJ);
        fill_valve      = !r_dir;
        drain_valve     = r_dir;
        phase           = 2'd2;
      end
      S_LOAD_EXIT, S_WAIT_EXIT: begin
        counter_seconds = C_EXIT;
        counter_reset   = (r_state == S_LOAD_EXIT);
        gate_out_open   = 1'b1;
        phase           = 2'd3;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - directed self-checking bench for lock_sequencer

module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       dir;
  logic       abort;
  logic       r_exp;
  logic       use_cnt;
  logic       expire;
  logic [9:0] counter_seconds;
  logic       counter_reset;
  logic       gate_in_open;
  logic       gate_out_open;
  logic       fill_valve;
  logic       drain_valve;
  logic       busy;
  logic       done;
  logic [1:0] phase;

  logic [9:0] r_cnt;
  logic       w_cnt_exp;
  logic [18:0] w_obs;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [18:0] IDLE_V = {2'd0, 10'd0, 1'b1, 6'b000000};
  localparam logic [18:0] DONE_V = {2'd0, 10'd0, 1'b1, 6'b000011};

  always #5 clk = ~clk;

  lock_sequencer #(
    .ENTER_SECS(3),
    .FILL_SECS (4),
    .DRAIN_SECS(5),
    .EXIT_SECS (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .dir            (dir),
    .abort          (abort),
    .expire         (expire),
    .counter_seconds(counter_seconds),
    .counter_reset  (counter_reset),
    .gate_in_open   (gate_in_open),
    .gate_out_open  (gate_out_open),
    .fill_valve     (fill_valve),
    .drain_valve    (drain_valve),
    .busy           (busy),
    .done           (done),
    .phase          (phase)
  );

  // Seconds counter: counts from 0 after reset, pulses at secs-1.
  always_ff @(posedge clk) begin
    if (counter_reset) r_cnt <= 10'd0;
    else               r_cnt <= r_cnt + 10'd1;
  end
  assign w_cnt_exp = !counter_reset && (r_cnt == counter_seconds - 10'd1);
  assign expire    = use_cnt ? w_cnt_exp : r_exp;

  assign w_obs = {phase, counter_seconds, counter_reset, gate_in_open,
                  gate_out_open, fill_valve, drain_valve, busy, done};

  function automatic logic [18:0] vec(input logic [1:0] ph, input logic [9:0] s,
                                      input logic cr, input logic gi, input logic go,
                                      input logic fv, input logic dv, input logic b,
                                      input logic d);
    return {ph, s, cr, gi, go, fv, dv, b, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [18:0] e);
    tick();
    check(tag, 32'(w_obs), 32'(e));
  endtask

  // Full cycle with bench-driven expire; tog flips dir every cycle after start.
  task automatic run_cycle(input logic d, input logic tog);
    logic [9:0] s_adj;
    s_adj = d ? 10'd5 : 10'd4;
    start = 1'b1; dir = d;
    step("ld_ent", vec(2'd1, 10'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    start = 1'b0; if (tog) dir = ~dir;
    step("wt_ent", vec(2'd1, 10'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    r_exp = 1'b1; if (tog) dir = ~dir;
    step("ld_adj", vec(2'd2, s_adj, 1'b1, 1'b0, 1'b0, !d, d, 1'b1, 1'b0));
    r_exp = 1'b0; if (tog) dir = ~dir;
    step("wt_adj", vec(2'd2, s_adj, 1'b0, 1'b0, 1'b0, !d, d, 1'b1, 1'b0));
    r_exp = 1'b1; if (tog) dir = ~dir;
    step("ld_ext", vec(2'd3, 10'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    r_exp = 1'b0; if (tog) dir = ~dir;
    step("wt_ext", vec(2'd3, 10'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    r_exp = 1'b1;
    step("done", DONE_V);
    r_exp = 1'b0;
    step("idle_after", IDLE_V);
  endtask

  initial begin
    int n_cyc;
    int ent_wait;
    int crst0;
    logic seen;

    reset = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0;
    r_exp = 1'b0; use_cnt = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(w_obs), 32'(IDLE_V));
    reset = 1'b0;
    step("idle_hold", IDLE_V);

    // 1: raise cycle; 2: lower cycle with dir toggling
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b1);

    // 3: real counter attached
    use_cnt = 1'b1;
    start = 1'b1; dir = 1'b0;
    n_cyc = 0; ent_wait = 0; crst0 = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      start = 1'b0;
      n_cyc++;
      if (done) seen = 1'b1;
      if (phase == 2'd1 && !counter_reset) ent_wait++;
      if (!counter_reset) crst0++;
    end
    check("cnt_done_seen", 32'(seen), 32'd1);
    check("cnt_total", 32'(n_cyc), 32'd13);
    check("cnt_ent_wait", 32'(ent_wait), 32'd3);
    check("cnt_wait_cycles", 32'(crst0), 32'd9);
    step("cnt_idle", IDLE_V);
    use_cnt = 1'b0;

    // 4: abort coincident with expire in WAIT_ADJ
    start = 1'b1; dir = 1'b0;
    step("ab_ld_ent", vec(2'd1, 10'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    start = 1'b0;
    step("ab_wt_ent", vec(2'd1, 10'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    r_exp = 1'b1;
    step("ab_ld_adj", vec(2'd2, 10'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    r_exp = 1'b0;
    step("ab_wt_adj", vec(2'd2, 10'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    abort = 1'b1; r_exp = 1'b1;
    step("ab_idle", IDLE_V);
    abort = 1'b0; r_exp = 1'b0;
    step("ab_no_done", IDLE_V);
    // start + abort together in IDLE stays IDLE
    start = 1'b1; abort = 1'b1;
    step("ab_start_idle", IDLE_V);
    abort = 1'b0; start = 1'b0;
    run_cycle(1'b0, 1'b0);

    // 5: stray expire / start are ignored
    r_exp = 1'b1;
    step("ig_exp_idle", IDLE_V);
    r_exp = 1'b0; start = 1'b1; dir = 1'b1;
    step("ig_ld_ent", vec(2'd1, 10'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    start = 1'b0; r_exp = 1'b1;
    step("ig_exp_load", vec(2'd1, 10'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    r_exp = 1'b0;
    step("ig_wt_hold", vec(2'd1, 10'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    r_exp = 1'b1;
    step("ig_ld_adj", vec(2'd2, 10'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    r_exp = 1'b0;
    step("ig_wt_adj", vec(2'd2, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    r_exp = 1'b1;
    step("ig_ld_ext", vec(2'd3, 10'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    r_exp = 1'b0;
    step("ig_wt_ext", vec(2'd3, 10'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    start = 1'b1;
    step("ig_start_wait", vec(2'd3, 10'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    start = 1'b0; r_exp = 1'b1;
    step("ig_done", DONE_V);
    r_exp = 1'b0;
    step("ig_idle", IDLE_V);

    // 6: reset mid WAIT_ADJ beats abort and start
    start = 1'b1; dir = 1'b1;
    step("rs_ld_ent", vec(2'd1, 10'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    start = 1'b0; r_exp = 1'b1;
    step("rs_ld_adj_pre", vec(2'd1, 10'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    step("rs_ld_adj", vec(2'd2, 10'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    r_exp = 1'b0;
    step("rs_wt_adj", vec(2'd2, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    reset = 1'b1; abort = 1'b1; start = 1'b1;
    step("rs_outputs", IDLE_V);
    check("rs_dir", 32'(dut.r_dir), 32'd0);
    reset = 1'b0; abort = 1'b0; start = 1'b0; dir = 1'b0;
    step("rs_idle_after", IDLE_V);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
